// File: rtl/prio_encode_capture.sv
// Debounced 8-input priority encoder. A settled {ei,sw} change is encoded into
// registered x/ET/flag, and new_code/overrun give the consumer a handshake.
module prio_encode_capture #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       ei,
  input  logic       ack,
  output logic [2:0] x,
  output logic       ET,
  output logic       flag,
  output logic       new_code,
  output logic       overrun
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {HOLD, SETTLE, COMMIT} state_e;

  logic [8:0]    sync1_q, sync2_q;
  logic [8:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [2:0]    x_q, x_d;
  logic          et_q, et_d;
  logic          flag_q, flag_d;
  logic          new_code_q, new_code_d;
  logic          overrun_q, overrun_d;

  logic [8:0] v_s;
  logic [2:0] enc_x;
  logic [4:0] enc_triple;
  logic       changed;

  assign v_s = sync2_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      state_q    <= HOLD;
      x_q        <= '0;
      et_q       <= 1'b0;
      flag_q     <= 1'b0;
      new_code_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= {ei, sw};
      sync2_q    <= sync1_q;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      x_q        <= x_d;
      et_q       <= et_d;
      flag_q     <= flag_d;
      new_code_q <= new_code_d;
      overrun_q  <= overrun_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    if (v_s != cand_q) begin
      // Any difference, even a one-cycle glitch, restarts settling.
      cand_d  = v_s;
      cnt_d   = '0;
      state_d = SETTLE;
    end else begin
      unique case (state_q)
        HOLD:    state_d = HOLD;
        SETTLE:  begin
          if (cnt_q == CNT_LAST) state_d = COMMIT;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        COMMIT:  state_d = HOLD;
        default: state_d = HOLD;
      endcase
    end
  end

  // Later (higher) set bits overwrite earlier ones, giving top priority to bit 7.
  always_comb begin
    enc_x = '0;
    for (int i = 0; i < 8; i++) begin
      if (cand_q[i]) enc_x = 3'(i);
    end
    enc_triple = (cand_q[8] && (cand_q[7:0] != 8'h00)) ? {enc_x, 1'b1, 1'b1} : 5'b0;
  end

  assign changed = (state_q == COMMIT) && (enc_triple != {x_q, et_q, flag_q});

  always_comb begin
    {x_d, et_d, flag_d} = {x_q, et_q, flag_q};
    new_code_d = new_code_q;
    overrun_d  = overrun_q;
    if (changed) begin
      {x_d, et_d, flag_d} = enc_triple;
      new_code_d = 1'b1;
      // A commit coinciding with ack counts as consumed-then-replaced, not lost.
      overrun_d  = ack ? 1'b0 : (overrun_q | new_code_q);
    end else if (ack) begin
      new_code_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  assign x        = x_q;
  assign ET       = et_q;
  assign flag     = flag_q;
  assign new_code = new_code_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_prio_encode_capture.sv
// Directed bench for prio_encode_capture with DEB_CYCLES=4: commit latency,
// glitch rejection, no-change commits, overrun/ack handshake and reset.
module tb_prio_encode_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       ei;
  logic       ack;
  logic [2:0] x;
  logic       ET;
  logic       flag;
  logic       new_code;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prio_encode_capture #(.DEB_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .ei       (ei),
    .ack      (ack),
    .x        (x),
    .ET       (ET),
    .flag     (flag),
    .new_code (new_code),
    .overrun  (overrun)
  );

  // Advance n rising edges; sampling and driving happen 1ns after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] ex_x, input logic ex_et,
                           input logic ex_flag, input logic ex_nc, input logic ex_ov);
    check({tag, ".x"},        {5'b0, x},        {5'b0, ex_x});
    check({tag, ".ET"},       {7'b0, ET},       {7'b0, ex_et});
    check({tag, ".flag"},     {7'b0, flag},     {7'b0, ex_flag});
    check({tag, ".new_code"}, {7'b0, new_code}, {7'b0, ex_nc});
    check({tag, ".overrun"},  {7'b0, overrun},  {7'b0, ex_ov});
  endtask

  initial begin
    rst = 1'b1; sw = 8'h00; ei = 1'b1; ack = 1'b0;
    tick(2);
    check_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ei=1 alone at release encodes to the reset triple: no new_code.
    rst = 1'b0;
    tick(10);
    check_out("idle_after_release", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 0x28: unchanged for 7 edges, committed on the 8th (DEB_CYCLES+3 after first sample).
    sw = 8'h28;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      check_out("latency_hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick(1);
    check_out("commit_28", 3'd5, 1'b1, 1'b1, 1'b1, 1'b0);

    ack = 1'b1; tick(1); ack = 1'b0;
    check_out("ack_28", 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);

    // Lower-priority bit added: commit happens but triple is identical.
    sw = 8'h2A;
    tick(12);
    check_out("lower_bit_2A", 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);

    // 3-cycle pulse of bit 7 never settles.
    sw = 8'h80; tick(3); sw = 8'h2A;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      check_out("glitch_80", 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // ack with nothing pending changes nothing.
    ack = 1'b1; tick(1); ack = 1'b0;
    check_out("idle_ack", 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);

    // Commit left unacked, then a second changing commit raises overrun.
    sw = 8'h01;
    tick(12);
    check_out("commit_01", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    sw = 8'h81;
    tick(12);
    check_out("overrun_81", 3'd7, 1'b1, 1'b1, 1'b1, 1'b1);
    ack = 1'b1; tick(1); ack = 1'b0;
    check_out("ack_clears_both", 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);

    // Re-arm new_code, then disable with ack landing on the commit edge.
    sw = 8'h01;
    tick(12);
    check_out("rearm_01", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    sw = 8'h81; ei = 1'b0;
    tick(7);
    check_out("pre_disable", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    ack = 1'b1; tick(1); ack = 1'b0;
    check_out("disable_with_ack", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-settle, then 0xFF held through release commits after normal latency.
    ei = 1'b1; sw = 8'hFF;
    tick(4);
    rst = 1'b1; tick(1);
    check_out("reset_mid_settle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      check_out("post_reset_hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick(1);
    check_out("post_reset_FF", 3'd7, 1'b1, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prio_encode_capture.md
PRIO_ENCODE_CAPTURE -- requirements
Module: prio_encode_capture

Interface
REQ-001 Parameter DEB_CYCLES, default 16, number of consecutive stable cycles needed to accept an input change; legal range 2..65535.
REQ-002 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  reset; synchronous, active-high.
REQ-004 Port sw  input  8  raw asynchronous switch levels; bit i = request i, active-high.
REQ-005 Port ei  input  1  raw asynchronous encoder enable, active-high.
REQ-006 Port ack  input  1  consumer acknowledge of new_code, one-cycle pulse or level.
REQ-007 Port x  output  3  registered index of highest-priority active request.
REQ-008 Port ET  output  1  registered; 1 = valid code present, 0 = none/disabled (display shows 'E').
REQ-009 Port flag  output  1  registered; 1 = x is meaningful and may be latched by the display side.
REQ-010 Port new_code  output  1  registered; set when {x,ET,flag} changes, held until ack.
REQ-011 Port overrun  output  1  registered; set when a change is committed while new_code is still 1.

Function
REQ-012 The block SHALL pass the 9-bit vector {ei,sw} through a two-flop synchronizer; the second stage is v_s.
REQ-013 The block SHALL hold a 9-bit candidate register cand and a counter cnt, width ceil(log2(DEB_CYCLES)), saturating never needed.
REQ-014 The FSM SHALL have states HOLD, SETTLE and COMMIT; reset state HOLD.
REQ-015 In any state, v_s != cand SHALL load cand<=v_s, cnt<=0, next state SETTLE (a glitch restarts settling).
REQ-016 In SETTLE with v_s == cand, cnt SHALL increment; when cnt == DEB_CYCLES-1, next state COMMIT.
REQ-017 COMMIT SHALL last exactly one cycle, then go to HOLD (unless REQ-015 applies).
REQ-018 In COMMIT, encoding SHALL be: ei=0 or sw-part of cand==0 -> x=0, ET=0, flag=0; else x = highest set index of cand[7:0], ET=1, flag=1.
REQ-019 x, ET and flag SHALL update only on the COMMIT edge, never on transient inputs.
REQ-020 Latency: a change on sw/ei held stable SHALL reach x/ET/flag at the rising edge DEB_CYCLES+3 cycles after the first edge sampling it.
REQ-021 On COMMIT, if the encoded triple differs from the current {x,ET,flag}, new_code SHALL be set; if identical (e.g. lower-priority bit toggles), no outputs change.
REQ-022 If new_code is already 1 at a changing COMMIT, overrun SHALL be set; x/ET/flag still update.
REQ-023 ack=1 SHALL clear new_code and overrun on the next edge; a changing COMMIT in the same cycle as ack SHALL leave new_code=1 and overrun=0 (set wins over ack, overrun not raised).
REQ-024 ack while new_code=0 SHALL have no effect.

Reset
REQ-025 With rst=1 at a clock edge: synchronizer stages=0, cand=0, cnt=0, state=HOLD, x=0, ET=0, flag=0, new_code=0, overrun=0.
REQ-026 rst SHALL override every other input, including mid-SETTLE or COMMIT; no commit occurs in a reset cycle.
REQ-027 Inputs non-zero at reset release SHALL be treated as a change and committed after the normal REQ-020 latency.

Verification
REQ-028 DEB_CYCLES=4, ei=1, sw 0x00->0x28 held -> at edge 7 x=5, ET=1, flag=1, new_code=1; no earlier output change.
REQ-029 sw=0x28 committed, then sw->0x2A (bit1 added) held -> after settle no change to x/ET/flag, new_code not re-asserted.
REQ-030 sw pulses 0x80 for 3 cycles then back to 0x00 with DEB_CYCLES=4 -> x/ET/flag never change, new_code stays 0.
REQ-031 Commit x=5 without ack, then sw->0x81 held -> x=7, new_code=1, overrun=1; ack pulse -> both 0 next edge.
REQ-032 ei 1->0 with sw=0x81 held -> after latency x=0, ET=0, flag=0, new_code=1; ack coincident with that COMMIT edge -> new_code stays 1, overrun 0.
REQ-033 rst asserted mid-SETTLE with sw=0xFF -> all outputs 0 next edge; after release sw=0xFF held -> x=7, ET=1 at edge DEB_CYCLES+3.
